// File: rtl/pipeline_pkg.sv
// Types and constants shared by the RV32I pipeline stages.
// Holds the control bundle layout and the forwarding select encoding.
package pipeline_pkg;

    localparam int XLEN = 32;
    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic [2:0] alu_control;
        logic       alu_src;
    } ctrl_t;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    function automatic logic is_load(input ctrl_t c);
        return c.result_src == RESULT_SRC_LOAD;
    endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux3.sv
// Three-way operand mux for EX-stage forwarding.
// The reserved select value 2'b11 falls back to the registered operand.
module fwd_mux3 #(
    parameter int W = 32
) (
    input  logic [1:0]   sel_i,
    input  logic [W-1:0] reg_i,
    input  logic [W-1:0] wb_i,
    input  logic [W-1:0] mem_i,
    output logic [W-1:0] out_o
);
    import pipeline_pkg::*;

    always_comb begin
        out_o = reg_i;
        case (sel_i)
            FWD_WB:  out_o = wb_i;
            FWD_MEM: out_o = mem_i;
            default: out_o = reg_i;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch flush,
// forwarding operand muxes and saturating bubble/flush event counters.
module id_ex_stage #(
    parameter int XLEN  = pipeline_pkg::XLEN,
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [XLEN-1:0]      rd1_d,
    input  logic [XLEN-1:0]      rd2_d,
    input  logic [4:0]           rs1_d,
    input  logic [4:0]           rs2_d,
    input  logic [4:0]           rd_d,
    input  logic [XLEN-1:0]      imm_ext_d,
    input  logic [XLEN-1:0]      pc_d,
    input  logic [XLEN-1:0]      pc_plus4_d,
    input  pipeline_pkg::ctrl_t  ctrl_d,
    input  logic                 pc_src_ex,
    input  logic [1:0]           forward_ae,
    input  logic [1:0]           forward_be,
    input  logic [XLEN-1:0]      alu_result_mem,
    input  logic [XLEN-1:0]      result_wb,
    output logic [4:0]           rs1_ex,
    output logic [4:0]           rs2_ex,
    output logic [4:0]           rd_ex,
    output pipeline_pkg::ctrl_t  ctrl_ex,
    output logic [XLEN-1:0]      imm_ext_ex,
    output logic [XLEN-1:0]      pc_ex,
    output logic [XLEN-1:0]      pc_plus4_ex,
    output logic [XLEN-1:0]      src_a_ex,
    output logic [XLEN-1:0]      src_b_ex,
    output logic [XLEN-1:0]      write_data_ex,
    output logic                 stall_f,
    output logic                 stall_d,
    output logic                 flush_d,
    output logic                 flush_e,
    output logic [CNT_W-1:0]     bubble_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);
    import pipeline_pkg::*;

    logic [4:0]      rs1_q, rs1_nd;
    logic [4:0]      rs2_q, rs2_nd;
    logic [4:0]      rd_q, rd_nd;
    ctrl_t           ctrl_q, ctrl_nd;
    logic [XLEN-1:0] imm_q, imm_nd;
    logic [XLEN-1:0] pc_q, pc_nd;
    logic [XLEN-1:0] pc4_q, pc4_nd;
    logic [XLEN-1:0] rd1_q, rd1_nd;
    logic [XLEN-1:0] rd2_q, rd2_nd;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_nd;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_nd;

    logic lwstall;
    logic [XLEN-1:0] fwd_b;

    // A load in EX whose destination is read by the instruction in decode.
    assign lwstall = is_load(ctrl_q) && (rd_q != 5'd0) &&
                     ((rs1_d == rd_q) || (rs2_d == rd_q));

    assign stall_f = lwstall;
    assign stall_d = lwstall;
    assign flush_d = pc_src_ex;
    assign flush_e = lwstall | pc_src_ex;

    always_comb begin
        rs1_nd  = rs1_d;
        rs2_nd  = rs2_d;
        rd_nd   = rd_d;
        ctrl_nd = ctrl_d;
        imm_nd  = imm_ext_d;
        pc_nd   = pc_d;
        pc4_nd  = pc_plus4_d;
        rd1_nd  = rd1_d;
        rd2_nd  = rd2_d;
        if (flush_e) begin
            rs1_nd  = '0;
            rs2_nd  = '0;
            rd_nd   = '0;
            ctrl_nd = '0;
            imm_nd  = '0;
            pc_nd   = '0;
            pc4_nd  = '0;
            rd1_nd  = '0;
            rd2_nd  = '0;
        end
    end

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        bubble_cnt_nd = bubble_cnt_q;
        flush_cnt_nd  = flush_cnt_q;
        if (lwstall && (bubble_cnt_q != '1)) begin
            bubble_cnt_nd = bubble_cnt_q + CNT_W'(1);
        end
        if (pc_src_ex && (flush_cnt_q != '1)) begin
            flush_cnt_nd = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
            ctrl_q       <= '0;
            imm_q        <= '0;
            pc_q         <= '0;
            pc4_q        <= '0;
            rd1_q        <= '0;
            rd2_q        <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            rs1_q        <= rs1_nd;
            rs2_q        <= rs2_nd;
            rd_q         <= rd_nd;
            ctrl_q       <= ctrl_nd;
            imm_q        <= imm_nd;
            pc_q         <= pc_nd;
            pc4_q        <= pc4_nd;
            rd1_q        <= rd1_nd;
            rd2_q        <= rd2_nd;
            bubble_cnt_q <= bubble_cnt_nd;
            flush_cnt_q  <= flush_cnt_nd;
        end
    end

    fwd_mux3 #(.W(XLEN)) u_fwd_a (
        .sel_i (forward_ae),
        .reg_i (rd1_q),
        .wb_i  (result_wb),
        .mem_i (alu_result_mem),
        .out_o (src_a_ex)
    );

    fwd_mux3 #(.W(XLEN)) u_fwd_b (
        .sel_i (forward_be),
        .reg_i (rd2_q),
        .wb_i  (result_wb),
        .mem_i (alu_result_mem),
        .out_o (fwd_b)
    );

    assign write_data_ex = fwd_b;
    assign src_b_ex      = ctrl_q.alu_src ? imm_q : fwd_b;

    assign rs1_ex      = rs1_q;
    assign rs2_ex      = rs2_q;
    assign rd_ex       = rd_q;
    assign ctrl_ex     = ctrl_q;
    assign imm_ext_ex  = imm_q;
    assign pc_ex       = pc_q;
    assign pc_plus4_ex = pc4_q;
    assign bubble_cnt  = bubble_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule
